// File: rtl/ps2_transmitter.sv
// ps2_transmitter: host-to-device PS/2 byte sender (inhibit, request, 8 data bits LSB first, odd parity, stop, device ACK)
// Ports: CLK100MHZ/CPU_RESETN (sync active-low) clock and reset; PS2_CLK/PS2_DATA sensed line levels;
// tx_data/tx_valid/tx_ready command handshake; ps2_clk_oe/ps2_data_oe open-drain pull-low enables;
// tx_done/tx_error single-cycle completion pulses.
module ps2_transmitter #(
  parameter int INHIBIT_CYCLES = 12_000,
  parameter int START_TIMEOUT_CYCLES = 1_500_000,
  parameter int PACKET_TIMEOUT_CYCLES = 200_000
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESETN,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_done,
  output logic       tx_error
);
  localparam int MAX_A = (INHIBIT_CYCLES > START_TIMEOUT_CYCLES) ? INHIBIT_CYCLES : START_TIMEOUT_CYCLES;
  localparam int MAX = (MAX_A > PACKET_TIMEOUT_CYCLES) ? MAX_A : PACKET_TIMEOUT_CYCLES;
  localparam int W = ($clog2(MAX) < 1) ? 1 : $clog2(MAX);
  localparam logic [2:0] IDLE = 3'd0, INHIBIT = 3'd1, REQ = 3'd2, START = 3'd3,
                         DATA = 3'd4, PARITY = 3'd5, STOP = 3'd6, WAIT_IDLE = 3'd7;
  logic [2:0] state_q, state_d, bit_q, bit_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [7:0] byte_q, byte_d;
  logic par_q, par_d;
  logic [1:0] clk_s_q, data_s_q;
  logic clk_prev_q, fe;
  logic ready_q, ready_d, clk_oe_q, clk_oe_d, data_oe_q, data_oe_d, done_q, done_d, err_q, err_d;
  assign fe = clk_prev_q & ~clk_s_q[1];
  always_comb begin
    state_d = state_q;
    cnt_d = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    bit_d = bit_q;
    byte_d = byte_q;
    par_d = par_q;
    done_d = 1'b0;
    err_d = 1'b0;
    // one packet-wide budget covers DATA through WAIT_IDLE, so those states do not reload the counter
    if (state_q >= DATA && cnt_q == '0) begin
      state_d = IDLE;
      err_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: if (tx_valid && ready_q) begin
          state_d = INHIBIT;
          cnt_d = W'(INHIBIT_CYCLES - 1);
          byte_d = tx_data;
          par_d = ~^tx_data;
        end
        INHIBIT: state_d = (cnt_q == '0) ? REQ : INHIBIT;
        REQ: begin
          state_d = START;
          cnt_d = W'(START_TIMEOUT_CYCLES - 1);
        end
        START: if (fe) begin
          state_d = DATA;
          bit_d = 3'd0;
          cnt_d = W'(PACKET_TIMEOUT_CYCLES - 1);
        end else if (cnt_q == '0) begin
          state_d = IDLE;
          err_d = 1'b1;
        end
        DATA: if (fe) begin
          state_d = (bit_q == 3'd7) ? PARITY : DATA;
          bit_d = (bit_q == 3'd7) ? bit_q : bit_q + 3'd1;
        end
        PARITY: state_d = fe ? STOP : PARITY;
        STOP: if (fe) begin
          state_d = data_s_q[1] ? IDLE : WAIT_IDLE;
          err_d = data_s_q[1];
        end
        WAIT_IDLE: if (clk_s_q[1] && data_s_q[1]) begin
          state_d = IDLE;
          done_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // outputs are decoded from the next state so every pin comes straight from a flop
  always_comb begin
    ready_d = (state_d == IDLE) && !done_d && !err_d;
    clk_oe_d = (state_d == INHIBIT) || (state_d == REQ);
    data_oe_d = (state_d == REQ) || (state_d == START) ||
                ((state_d == DATA) && !byte_d[bit_d]) || ((state_d == PARITY) && !par_d);
  end
  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      byte_q <= '0;
      par_q <= 1'b0;
      clk_s_q <= 2'b11;
      data_s_q <= 2'b11;
      clk_prev_q <= 1'b1;
      ready_q <= 1'b1;
      clk_oe_q <= 1'b0;
      data_oe_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      byte_q <= byte_d;
      par_q <= par_d;
      clk_s_q <= {clk_s_q[0], PS2_CLK};
      data_s_q <= {data_s_q[0], PS2_DATA};
      clk_prev_q <= clk_s_q[1];
      ready_q <= ready_d;
      clk_oe_q <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  assign tx_ready = ready_q;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign tx_done = done_q;
  assign tx_error = err_q;
endmodule

// File: tb/tb_ps2_transmitter.sv
// tb_ps2_transmitter: directed bench for ps2_transmitter with an open-drain keyboard model
module tb_ps2_transmitter;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic tx_valid = 1'b0;
  logic tx_ready, ps2_clk_oe, ps2_data_oe, tx_done, tx_error;
  logic line_clk, line_data;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int wide_cnt = 0;
  logic done_prev = 1'b0;
  logic err_prev = 1'b0;
  assign line_clk = ~ps2_clk_oe & dev_clk;
  assign line_data = ~ps2_data_oe & dev_data;
  always #5 clk = ~clk;
  ps2_transmitter #(
    .INHIBIT_CYCLES(20),
    .START_TIMEOUT_CYCLES(2000),
    .PACKET_TIMEOUT_CYCLES(5000)
  ) dut (
    .CLK100MHZ(clk),
    .CPU_RESETN(rstn),
    .PS2_CLK(line_clk),
    .PS2_DATA(line_data),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .tx_done(tx_done),
    .tx_error(tx_error)
  );
  always @(negedge clk) begin
    done_cnt += int'(tx_done);
    err_cnt += int'(tx_error);
    both_cnt += int'(tx_done && tx_error);
    wide_cnt += int'((tx_done && done_prev) || (tx_error && err_prev));
    done_prev = tx_done;
    err_prev = tx_error;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic request(input logic [7:0] b);
    int n, dn, guard;
    guard = 0;
    while (!tx_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    tx_data = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("accept_ready", {31'd0, tx_ready}, 32'd0);
    chk("accept_clk_oe", {31'd0, ps2_clk_oe}, 32'd1);
    n = 1;
    dn = int'(ps2_data_oe);
    guard = 0;
    while (ps2_clk_oe && guard < 200) begin
      @(negedge clk);
      guard++;
      if (ps2_clk_oe) begin
        n++;
        dn += int'(ps2_data_oe);
      end
    end
    chk("inhibit_len", n, 32'd21);
    chk("req_len", dn, 32'd1);
    chk("start_bit", {31'd0, ps2_data_oe}, 32'd1);
  endtask
  task automatic frame(input bit ack, input int abort_after, input bit inject, output logic [9:0] got);
    got = '0;
    repeat (10) @(negedge clk);
    for (int k = 1; k <= 11; k++) begin
      if (k == 11 && ack) dev_data = 1'b0;
      repeat (5) @(negedge clk);
      dev_clk = 1'b0;
      repeat (40) @(negedge clk);
      if (inject && k == 3) begin
        tx_data = 8'h55;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("busy_ready", {31'd0, tx_ready}, 32'd0);
      end
      dev_clk = 1'b1;
      if (k <= 10) got[k-1] = line_data;
      if (k == abort_after) begin
        rstn = 1'b0;
        @(negedge clk);
        chk("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        chk("rst_data_oe", {31'd0, ps2_data_oe}, 32'd0);
        chk("rst_ready", {31'd0, tx_ready}, 32'd1);
        chk("rst_pulses", {30'd0, tx_done, tx_error}, 32'd0);
        rstn = 1'b1;
        return;
      end
      repeat (40) @(negedge clk);
    end
  endtask
  task automatic finish_ack();
    int n;
    dev_data = 1'b1;
    n = 0;
    while (!tx_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("done_latency", n, 32'd3);
    chk("done_ready_low", {31'd0, tx_ready}, 32'd0);
    @(negedge clk);
    chk("ready_after_done", {31'd0, tx_ready}, 32'd1);
  endtask
  initial begin
    logic [9:0] got;
    int d0, e0, n;
    repeat (3) @(negedge clk);
    chk("reset_ready", {31'd0, tx_ready}, 32'd1);
    chk("reset_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    chk("reset_pulses", {30'd0, tx_done, tx_error}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    // 0xED: bits 1,0,1,1,0,1,1,1 LSB first, parity 1, stop 1
    d0 = done_cnt; e0 = err_cnt;
    request(8'hED);
    frame(1'b1, 0, 1'b0, got);
    finish_ack();
    chk("ed_bits", got, 32'h3ED);
    chk("ed_done", done_cnt - d0, 32'd1);
    chk("ed_err", err_cnt - e0, 32'd0);
    // 0x01: parity 0
    d0 = done_cnt;
    request(8'h01);
    frame(1'b1, 0, 1'b0, got);
    finish_ack();
    chk("01_bits", got, 32'h201);
    chk("01_done", done_cnt - d0, 32'd1);
    // 0x00: parity 1
    d0 = done_cnt;
    request(8'h00);
    frame(1'b1, 0, 1'b0, got);
    finish_ack();
    chk("00_bits", got, 32'h300);
    chk("00_done", done_cnt - d0, 32'd1);
    // NACK: data left high at edge 11
    d0 = done_cnt; e0 = err_cnt;
    request(8'hF3);
    frame(1'b0, 0, 1'b0, got);
    repeat (20) @(negedge clk);
    chk("nack_bits", got, 32'h3F3);
    chk("nack_err", err_cnt - e0, 32'd1);
    chk("nack_done", done_cnt - d0, 32'd0);
    chk("nack_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    chk("nack_ready", {31'd0, tx_ready}, 32'd1);
    // device never clocks: error 2000 cycles after START entry
    d0 = done_cnt; e0 = err_cnt;
    request(8'hFF);
    n = 0;
    while (!tx_error && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("start_timeout", n, 32'd2000);
    chk("timeout_data_oe", {31'd0, ps2_data_oe}, 32'd0);
    chk("timeout_done", done_cnt - d0, 32'd0);
    @(negedge clk);
    chk("timeout_ready", {31'd0, tx_ready}, 32'd1);
    chk("timeout_err", err_cnt - e0, 32'd1);
    // reset after bit 4 has been sampled, then a clean 0xFF
    request(8'hA5);
    d0 = done_cnt; e0 = err_cnt;
    frame(1'b1, 5, 1'b0, got);
    dev_data = 1'b1;
    repeat (100) @(negedge clk);
    chk("abort_no_pulses", (done_cnt - d0) + (err_cnt - e0), 32'd0);
    request(8'hFF);
    frame(1'b1, 0, 1'b0, got);
    finish_ack();
    chk("ff_bits", got, 32'h3FF);
    chk("ff_done", done_cnt - d0, 32'd1);
    // tx_valid with 0x55 mid-byte is ignored
    d0 = done_cnt;
    request(8'h3C);
    frame(1'b1, 0, 1'b1, got);
    finish_ack();
    chk("ignore_bits", got, 32'h33C);
    repeat (100) @(negedge clk);
    chk("ignore_done", done_cnt - d0, 32'd1);
    chk("ignore_idle", {30'd0, ps2_clk_oe, tx_ready}, 32'd1);
    chk("never_both", both_cnt, 32'd0);
    chk("pulse_width", wide_cnt, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
